// File: rtl/alsu_arbiter.sv
// Two-requester command arbiter that time-shares one ALSU and returns its result.
// Build with ALSU_ARB_RR_EN defined for round-robin grants. The default build uses fixed r0 priority.
module alsu_arbiter #(
  parameter int EXEC_CYCLES = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_valid,
  input  logic        r1_valid,
  output logic        r0_ready,
  output logic        r1_ready,
  input  logic [15:0] r0_cmd,
  input  logic [15:0] r1_cmd,
  output logic [15:0] alsu_cmd,
  input  logic [5:0]  alsu_out,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [5:0]  rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  localparam int MAXC = (EXEC_CYCLES > LOCK_CYCLES) ?
                        EXEC_CYCLES : LOCK_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP,
    LOCK
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [15:0]   cmd_q;
  logic [15:0]   cmd_d;
  logic          rsp_valid_q;
  logic          rsp_id_q;
  logic [5:0]    rsp_data_q;
  logic          rsp_err_q;
  logic [7:0]    err_cnt_q;
  logic [7:0]    err_cnt_d;

  logic          gnt;
  logic          idle;
  logic          hs;
  logic [2:0]    op;
  logic          red;
  logic          cmd_inv;

  assign idle = (state_q == IDLE);

  // gnt selects the requester that wins this cycle (0 = r0, 1 = r1)
`ifdef ALSU_ARB_RR_EN
  logic last_grant_q;

  always_comb begin
    gnt = 1'b0;
    if (r0_valid && r1_valid) begin
      gnt = ~last_grant_q;
    end else if (r1_valid) begin
      gnt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else if (hs) begin
      last_grant_q <= gnt;
    end
  end
`else
  always_comb begin
    gnt = r1_valid & ~r0_valid;
  end
`endif

  assign r0_ready = idle & r0_valid & ~gnt;
  assign r1_ready = idle & r1_valid & gnt;
  assign hs       = r0_ready | r1_ready;
  assign cmd_d    = gnt ? r1_cmd : r0_cmd;

  // Reductions are only meaningful for AND/XOR.
  // Bypass does not rescue an illegal op.
  assign op      = cmd_q[9:7];
  assign red     = cmd_q[3] | cmd_q[2];
  assign cmd_inv = (op[2:1] == 2'b11) ||
                   (red && (op[2:1] != 2'b00));

  assign err_cnt_d = (err_cnt_q == 8'hff) ?
                     err_cnt_q : err_cnt_q + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (hs) begin
            cmd_q    <= cmd_d;
            rsp_id_q <= gnt;
            cnt_q    <= CW'(EXEC_CYCLES - 1);
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q == '0) begin
            rsp_data_q  <= alsu_out;
            rsp_err_q   <= cmd_inv;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        RESP: begin
          rsp_err_q <= 1'b0;
          if (rsp_err_q) begin
            err_cnt_q <= err_cnt_d;
            cnt_q     <= CW'(LOCK_CYCLES - 1);
            state_q   <= LOCK;
          end else begin
            state_q <= IDLE;
          end
        end
        LOCK: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
      endcase
    end
  end

  assign alsu_cmd  = cmd_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = ~idle;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_alsu_arbiter.sv
// Self-checking bench for alsu_arbiter.
// A transaction-level model is compared every cycle, with directed and random traffic.
module tb_alsu_arbiter;

  localparam int E = 3;
  localparam int L = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_valid, r1_valid;
  logic        r0_ready, r1_ready;
  logic [15:0] r0_cmd, r1_cmd;
  logic [15:0] alsu_cmd;
  logic [5:0]  alsu_out;
  logic        rsp_valid, rsp_id, rsp_err, busy;
  logic [5:0]  rsp_data;
  logic [7:0]  err_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alsu_arbiter #(.EXEC_CYCLES(E), .LOCK_CYCLES(L)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r1_valid(r1_valid),
    .r0_ready(r0_ready), .r1_ready(r1_ready),
    .r0_cmd(r0_cmd), .r1_cmd(r1_cmd),
    .alsu_cmd(alsu_cmd), .alsu_out(alsu_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .err_cnt(err_cnt)
  );

  // Behavioural ALSU attached to the arbiter.
  function automatic logic [5:0] alsu_fn(input logic [15:0] c);
    logic [2:0] a, b, op;
    logic [5:0] ab, r;
    a  = c[15:13];
    b  = c[12:10];
    op = c[9:7];
    ab = {a, b};
    r  = '0;
    if (c[1]) r = {3'd0, a};
    else if (c[0]) r = {3'd0, b};
    else begin
      case (op)
        3'd0: r = c[3] ? {5'd0, &a} : c[2] ? {5'd0, &b} : {3'd0, a & b};
        3'd1: r = c[3] ? {5'd0, ^a} : c[2] ? {5'd0, ^b} : {3'd0, a ^ b};
        3'd2: r = 6'(a) + 6'(b) + 6'(c[6]);
        3'd3: r = 6'(a) * 6'(b);
        3'd4: r = c[4] ? {ab[4:0], c[5]} : {c[5], ab[5:1]};
        3'd5: r = c[4] ? {ab[4:0], ab[5]} : {ab[0], ab[5:1]};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  always_comb alsu_out = alsu_fn(alsu_cmd);

  function automatic bit is_inv(input logic [15:0] c);
    int op;
    op = int'(c[9:7]);
    return (op >= 6) || ((c[3] | c[2]) && op > 1);
  endfunction

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  // Transaction-level model: a command occupies the unit for a fixed span.
  bit          rr_mode;
  int          t = 0;
  int          free_at = 0;
  int          resp_t = 0;
  bit          pend = 0;
  bit          m_id, m_err, m_last;
  logic [5:0]  m_data;
  logic [15:0] m_cmd;
  int          m_errcnt = 0;

  initial begin
`ifdef ALSU_ARB_RR_EN
    rr_mode = 1'b1;
`else
    rr_mode = 1'b0;
`endif
    m_last = 1'b1;
    m_cmd  = '0;
  end

  always @(negedge clk) begin
    bit free, g, e0, e1, erv;
    logic [15:0] c;
    t++;
    if (rst) begin
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_alsu_cmd", alsu_cmd, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_err", rsp_err, 0);
      free_at  = 0;
      pend     = 0;
      m_cmd    = '0;
      m_errcnt = 0;
      m_last   = 1'b1;
    end else begin
      free = (t >= free_at);
      g = 1'b0;
      if (r0_valid && r1_valid) g = rr_mode ? !m_last : 1'b0;
      else if (r1_valid) g = 1'b1;
      e0 = free && r0_valid && !g;
      e1 = free && r1_valid && g;
      chk("r0_ready", r0_ready, e0);
      chk("r1_ready", r1_ready, e1);
      chk("busy", busy, !free);
      chk("alsu_cmd", alsu_cmd, m_cmd);
      chk("err_cnt", err_cnt, m_errcnt);
      erv = pend && (t == resp_t);
      chk("rsp_valid", rsp_valid, erv);
      if (erv) begin
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_data", rsp_data, m_data);
        chk("rsp_err", rsp_err, m_err);
        if (m_err && m_errcnt < 255) m_errcnt++;
        pend = 0;
      end
      if (e0 || e1) begin
        c       = e1 ? r1_cmd : r0_cmd;
        m_cmd   = c;
        m_id    = e1;
        m_last  = e1;
        m_err   = is_inv(c);
        m_data  = alsu_fn(c);
        pend    = 1;
        resp_t  = t + E + 1;
        free_at = t + E + 2 + (m_err ? L : 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy, 0);
    step();
  endtask

  // Drives one command and checks the response at its fixed latency.
  task automatic send(input bit id, input logic [15:0] c,
                      input int exp_d, input bit exp_e,
                      input string nm);
    bit got;
    step();
    if (id) begin r1_valid = 1'b1; r1_cmd = c; end
    else begin r0_valid = 1'b1; r0_cmd = c; end
    got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      got = id ? r1_ready : r0_ready;
    end
    chk({nm, "_handshake"}, got, 1);
    step();
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    repeat (E) @(negedge clk);
    @(negedge clk);
    chk({nm, "_rsp_valid"}, rsp_valid, 1);
    chk({nm, "_rsp_id"}, rsp_id, id);
    chk({nm, "_rsp_err"}, rsp_err, exp_e);
    if (exp_d >= 0) chk({nm, "_rsp_data"}, rsp_data, exp_d);
  endtask

  function automatic logic [15:0] rand_cmd();
    logic [15:0] c;
    c = 16'($urandom);
    if ($urandom_range(3) != 0) c[3:2] = 2'b00;
    if ($urandom_range(3) != 0) c[1:0] = 2'b00;
    return c;
  endfunction

  localparam logic [15:0] C_MUL = {3'd3, 3'd2, 3'b011, 7'b0};
  localparam logic [15:0] C_ADD = {3'd7, 3'd7, 3'b010, 7'b1000000};
  localparam logic [15:0] C_BAD = {3'd1, 3'd1, 3'b110, 7'b0};

  initial begin
    bit ids[4];
    int k;
    int n;
    bit seen;
    rst = 1'b0;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    r0_cmd = '0;
    r1_cmd = '0;
    #1 rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    send(0, C_MUL, 6, 0, "mul");
    send(1, C_ADD, 15, 0, "add");
    send(0, C_BAD, -1, 1, "bad");
    for (int i = 0; i < L; i++) begin
      @(negedge clk);
      chk("lock_busy", busy, 1);
    end
    @(negedge clk);
    chk("lock_done", busy, 0);
    chk("err_cnt_one", err_cnt, 1);
    send(0, C_MUL, 6, 0, "after_lock");

    do_reset();
    r0_cmd = C_MUL;
    r1_cmd = C_ADD;
    r0_valid = 1'b1;
    r1_valid = 1'b1;
    k = 0;
    n = 0;
    while (k < 4 && n < 60) begin
      @(negedge clk);
      if (rsp_valid) begin
        ids[k] = rsp_id;
        k++;
      end
      n++;
    end
    step();
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    chk("burst_count", k, 4);
    for (int i = 0; i < 4; i++)
      chk("burst_id", ids[i], rr_mode ? (i % 2) : 0);

    wait_idle();
    r0_cmd = C_MUL;
    r0_valid = 1'b1;
    @(negedge clk);
    chk("abort_hs", r0_ready, 1);
    step();
    r0_valid = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("abort_alsu_cmd", alsu_cmd, 0);
    chk("abort_busy", busy, 0);
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("abort_no_rsp", seen, 0);
    send(0, C_ADD, 15, 0, "post_abort");

    // A stream of illegal commands drives err_cnt into saturation.
    do_reset();
    r0_cmd = C_BAD;
    r0_valid = 1'b1;
    repeat (270 * (E + 2 + L)) @(negedge clk);
    chk("err_cnt_sat", err_cnt, 255);
    step();
    r0_valid = 1'b0;
    wait_idle();

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step();
      rst = ($urandom_range(399) == 0);
      r0_valid = ($urandom_range(3) != 0);
      r1_valid = ($urandom_range(2) != 0);
      r0_cmd = rand_cmd();
      r1_cmd = rand_cmd();
    end
    step();
    rst = 1'b0;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    repeat (30) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alsu_arbiter.md
ALSU_ARBITER -- requirements
Module: alsu_arbiter

Interface
REQ-001 Parameters SHALL be: EXEC_CYCLES, default 3, cycles a command is held on the ALSU before its output is sampled.
REQ-002 Parameters SHALL also include LOCK_CYCLES, default 16, cycles waited after an invalid command while the ALSU blinks its LEDs.
REQ-003 Ports SHALL be, in this order:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- r0_valid, r1_valid  in  1  requester command valid.
- r0_ready, r1_ready  out  1  requester command accepted.
- r0_cmd, r1_cmd  in  16  command {A[2:0], B[2:0], opcode[2:0], cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B}, MSB first.
- alsu_cmd  out  16  same packing, fanned out to the ALSU inputs.
- alsu_out  in  6  ALSU out.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_id  out  1  requester served (0/1).
- rsp_data  out  6  sampled ALSU result.
- rsp_err  out  1  command was invalid.
- busy  out  1  state != IDLE.
- err_cnt  out  8  count of invalid commands.

Function
REQ-004 FSM states SHALL be IDLE, EXEC, RESP, LOCK.
REQ-005 In IDLE, exactly one ready SHALL be high, only for the granted requester and only if its valid is high; both readys SHALL be low in every other state.
REQ-006 A handshake (valid & ready at a clock edge) SHALL latch the requester's cmd into cmd_reg, record rsp_id, and move IDLE->EXEC.
REQ-007 alsu_cmd SHALL equal cmd_reg at all times, held stable from the first EXEC cycle until the next handshake.
REQ-008 EXEC SHALL last exactly EXEC_CYCLES cycles; the edge ending the last EXEC cycle SHALL capture alsu_out into rsp_data and move to RESP.
REQ-009 The command SHALL be invalid when opcode is 3'b110 or 3'b111, or when (red_op_A | red_op_B) is set with an opcode other than 3'b000 or 3'b001; bypass SHALL NOT override invalidity.
REQ-010 RESP SHALL last one cycle, with rsp_valid=1 and rsp_err set to the invalid flag; it SHALL then go to LOCK if invalid, else to IDLE.
REQ-011 For an invalid command, rsp_data SHALL still be the captured alsu_out, which is don't-care to requesters.
REQ-012 LOCK SHALL last exactly LOCK_CYCLES cycles, then go to IDLE.
REQ-013 err_cnt SHALL increment on each RESP with rsp_err=1, saturating at 255.
REQ-014 With back-to-back valid commands, throughput SHALL be one command per EXEC_CYCLES+2 cycles; accept-to-rsp_valid latency SHALL be EXEC_CYCLES+1 cycles.
REQ-015 A requester deasserting valid without a handshake SHALL have no effect; cmd SHALL be sampled only at the handshake.

Reset
REQ-016 rst SHALL asynchronously force: state=IDLE, cmd_reg=0 (so alsu_cmd=0), rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, err_cnt=0, and last_grant=1.
REQ-017 Reset asserted in EXEC, RESP or LOCK SHALL abort the command; no response SHALL be produced and err_cnt SHALL be unchanged.
REQ-018 The first grant after reset SHALL go to r0 when both requesters are valid.

Configuration
REQ-019 With macro ALSU_ARB_RR_EN defined, arbitration SHALL be round-robin: when both are valid, grant the requester not named by last_grant; last_grant SHALL update at each handshake.
REQ-020 Without ALSU_ARB_RR_EN, arbitration SHALL be fixed priority: r0 always wins when both are valid, and last_grant SHALL be unused.
REQ-021 In both builds, a lone valid requester SHALL always be granted.

Verification
REQ-022 Reset, then r0_cmd = A=3, B=2, opcode=011 with the ALSU attached -> r0_ready for one cycle; rsp_valid 4 cycles later with rsp_id=0, rsp_data=6, rsp_err=0.
REQ-023 r1 sends opcode=010, A=7, B=7, cin=1 -> rsp_data=15, rsp_id=1.
REQ-024 r0 sends opcode=110 -> rsp_err=1 and err_cnt=1; busy stays high 16 cycles after RESP; the next command's result is correct.
REQ-025 r0 and r1 continuously valid for 4 commands -> with ALSU_ARB_RR_EN, rsp_id sequence is 0,1,0,1; without it, 0,0,0,0.
REQ-026 rst pulsed in the second EXEC cycle -> no rsp_valid, alsu_cmd=0, busy=0, and the next handshake is accepted normally.
